bus_cycle_sequencer: RTL

Upstream stage of the I/O port's bus control logic. It accepts single read/write requests from the internal master over a valid/ready handshake. For each request it generates a timed external bus cycle on ADDR, DATA_OUT/DATA_OE, CS_n, WR_n and RD_n, plus the internal qualifiers IWR and IRD that the downstream bus control uses to derive register and tri-state enables. Read data is captured and a one-cycle response is returned.

---
 rtl/bus_cycle_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: accepts single read/write requests over valid/ready and
// plays each one out as a timed external bus cycle (setup, strobe with optional
// wait extension, hold), then returns a one-cycle response with captured data.
// All bus-side outputs are registered from the next-state decode, so they line
// up with the state they belong to and have no combinational input path.

module bus_cycle_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int WAIT_MAX   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              BUS_WAIT,
    output logic              CS_n,
    output logic              WR_n,
    output logic              RD_n,
    output logic              IWR,
    output logic              IRD
);

    // One shared phase counter covers the longest of the three timed phases.
    localparam int PH_MAX_SH = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int PH_MAX    = (PH_MAX_SH > HOLD_CYC) ? PH_MAX_SH : HOLD_CYC;
    localparam int CNT_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int EXT_W     = $clog2(WAIT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [EXT_W-1:0] EXT_LIMIT   = EXT_W'(WAIT_MAX);
    localparam logic [EXT_W-1:0] EXT_ZERO    = {EXT_W{1'b0}};
    localparam logic [EXT_W-1:0] EXT_ONE     = EXT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [EXT_W-1:0]    ext_r, ext_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                err_r, err_s;
    logic                busy_s;
    logic                strobe_s;
    logic                leave_strobe_s;
    logic                finish_s;

    // Reset gates ready so nothing is accepted on a reset edge.
    assign req_ready = (state_r == IDLE) && !rst;

    // Next-state, phase counting, wait extension and request latching.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ext_s   = ext_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_s = SETUP;
                    cnt_s   = CNT_ZERO;
                    ext_s   = EXT_ZERO;
                    err_s   = 1'b0;
                    we_s    = req_we;
                    addr_s  = req_addr;
                    wdata_s = req_wdata;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = STROBE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STROBE: begin
                // The counter parks on the last nominal cycle; extensions are
                // tracked separately so BUS_WAIT is sampled there and beyond.
                if (cnt_r != STROBE_LAST) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else if (BUS_WAIT) begin
                    if (ext_r != EXT_LIMIT) begin
                        ext_s = ext_r + EXT_ONE;
                    end else begin
                        state_s = HOLD;
                        cnt_s   = CNT_ZERO;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = HOLD;
                    cnt_s   = CNT_ZERO;
                end
            end
            HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode of the upcoming state, used to register the bus outputs.
    always_comb begin
        busy_s         = (state_s != IDLE);
        strobe_s       = (state_s == STROBE);
        leave_strobe_s = (state_r == STROBE) && (state_s == HOLD);
        finish_s       = (state_r == HOLD) && (state_s == IDLE);
    end

    // State, counters and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            ext_r   <= EXT_ZERO;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ext_r   <= ext_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            err_r   <= err_s;
        end
    end

    // Registered bus pins, internal qualifiers and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ADDR      <= {ADDR_W{1'b0}};
            DATA_OUT  <= {DATA_W{1'b0}};
            DATA_OE   <= 1'b0;
            CS_n      <= 1'b1;
            WR_n      <= 1'b1;
            RD_n      <= 1'b1;
            IWR       <= 1'b0;
            IRD       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            CS_n      <= !busy_s;
            DATA_OE   <= busy_s && we_s;
            WR_n      <= !(strobe_s && we_s);
            IWR       <= strobe_s && we_s;
            RD_n      <= !(strobe_s && !we_s);
            IRD       <= strobe_s && !we_s;
            rsp_valid <= finish_s;
            rsp_err   <= finish_s && err_r;
            // Address and write data keep their last value once idle.
            if (busy_s) begin
                ADDR <= addr_s;
            end
            if (busy_s && we_s) begin
                DATA_OUT <= wdata_s;
            end
            if (leave_strobe_s) begin
                rsp_rdata <= we_r ? {DATA_W{1'b0}} : DATA_IN;
            end
        end
    end

endmodule
